// File: rtl/lutram_march_ctrl.sv
// March C- self-test sequencer for a 2**ADDR_WIDTH x 1 distributed RAM with async read.
// Optional feature: define MARCH_STOP_ON_FAIL_EN to end the run at the first mismatch.
module lutram_march_ctrl #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned ERR_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  ram_q_i,
   output logic [ADDR_WIDTH-1:0] ram_a_o,
   output logic                  ram_d_o,
   output logic                  ram_we_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o,
   output logic [2:0]            fail_elem_o,
   output logic [ERR_WIDTH-1:0]  err_count_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;

   state_t                r_state;
   logic [2:0]            r_elem;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic                  r_d;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_pass;
   logic [ADDR_WIDTH-1:0] r_fail_addr;
   logic [2:0]            r_fail_elem;
   logic [ERR_WIDTH-1:0]  r_err;

   logic                  w_exp;
   logic                  w_mismatch;
   logic [ERR_WIDTH-1:0]  w_err_next;
   logic                  w_down;
   logic                  w_last;
   logic [2:0]            w_next_elem;
   logic [ADDR_WIDTH-1:0] w_next_start;
   logic [ADDR_WIDTH-1:0] w_step_addr;
   logic                  w_finish;

   // Read expectations alternate 0,1,0,1,0 for E1..E5; writes alternate 0,1,0,1,0 for E0..E4.
   assign w_exp        = ~r_elem[0];
   assign w_mismatch   = (r_state == StRun) && !r_we && (ram_q_i != w_exp);
   assign w_err_next   = (w_mismatch && !(&r_err)) ? r_err + 1'b1 : r_err;
   assign w_down       = (r_elem == 3'd3) || (r_elem == 3'd4);
   assign w_last       = w_down ? (r_addr == '0) : (r_addr == AddrMax);
   assign w_next_elem  = r_elem + 3'd1;
   assign w_next_start = ((w_next_elem == 3'd3) || (w_next_elem == 3'd4)) ? AddrMax : '0;
   assign w_step_addr  = w_down ? r_addr - 1'b1 : r_addr + 1'b1;

`ifdef MARCH_STOP_ON_FAIL_EN
   assign w_finish = w_mismatch || ((r_elem == 3'd5) && !r_we && w_last);
`else
   assign w_finish = (r_elem == 3'd5) && !r_we && w_last;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= StIdle;
         r_elem      <= '0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_d         <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_elem <= '0;
         r_err       <= '0;
      end else begin
         unique case (r_state)
            StIdle, StDone: begin
               if (start_i) begin
                  r_state     <= StRun;
                  r_elem      <= '0;
                  r_addr      <= '0;
                  r_we        <= 1'b1;
                  r_d         <= 1'b0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_fail_addr <= '0;
                  r_fail_elem <= '0;
                  r_err       <= '0;
               end
            end
            StRun: begin
               r_err <= w_err_next;
               if (w_mismatch && (r_err == '0)) begin
                  r_fail_addr <= r_addr;
                  r_fail_elem <= r_elem;
               end
               if (w_finish) begin
                  r_state <= StDone;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
                  r_we    <= 1'b0;
                  r_d     <= 1'b0;
                  r_addr  <= '0;
               end else if (r_elem == 3'd0) begin
                  // E0 is write-only; the write at N-1 hands over to E1's first read.
                  if (w_last) begin
                     r_elem <= 3'd1;
                     r_addr <= '0;
                     r_we   <= 1'b0;
                  end else begin
                     r_addr <= w_step_addr;
                  end
               end else if (!r_we) begin
                  if (r_elem == 3'd5) begin
                     r_addr <= w_step_addr;
                  end else begin
                     r_we <= 1'b1;
                     r_d  <= r_elem[0];
                  end
               end else begin
                  r_we <= 1'b0;
                  if (w_last) begin
                     r_elem <= w_next_elem;
                     r_addr <= w_next_start;
                  end else begin
                     r_addr <= w_step_addr;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign ram_a_o     = r_addr;
   assign ram_d_o     = r_d;
   assign ram_we_o    = r_we;
   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign pass_o      = r_pass;
   assign fail_addr_o = r_fail_addr;
   assign fail_elem_o = r_fail_elem;
   assign err_count_o = r_err;

endmodule
